// File: rtl/aes_package.sv
// Shared types and constants for the AES engine sequencing controller.
package aes_package;

    localparam int unsigned AES_NB_WORDS = 4;
    localparam int unsigned AES_RC_W     = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PROC,
        ST_STORE,
        ST_DONE
    } aes_ctrl_state_t;

    typedef struct packed {
        logic [AES_RC_W-1:0] request_counter;
        logic                data_out_valid;
        logic                clear;
    } ctrl_engine_t;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic [15:0] blk_cnt;
    } flags_engine_t;

endpackage

// File: rtl/aes_ctrl_counter.sv
// Generic modulo-N counter, up or down, with clear, preload to N-1 and terminal count.
module aes_ctrl_counter #(
    parameter int unsigned N    = 4,
    parameter bit          DOWN = 1'b0,
    localparam int unsigned W   = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_c_o
);

    localparam logic [W-1:0] TOP = W'(N - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // clear beats preload beats count
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = TOP;
        end else if (en_i) begin
            if (DOWN) begin
                cnt_d = (cnt_q == '0) ? TOP : cnt_q - W'(1);
            end else begin
                cnt_d = (cnt_q == TOP) ? '0 : cnt_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign tc_c_o = DOWN ? (cnt_q == '0) : (cnt_q == TOP);

endmodule

// File: rtl/aes_engine_ctrl.sv
// Job sequencer for the AES engine: per-block load / process / store phases,
// streamer requests, and busy/done reporting back to the control slave.
module aes_engine_ctrl
    import aes_package::*;
#(
    parameter int unsigned NB_WORDS    = AES_NB_WORDS,
    parameter int unsigned PROC_CYCLES = 10,
    parameter int unsigned BLK_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [BLK_W-1:0] nb_blocks_i,
    input  logic             in_valid_i,
    input  logic             in_ready_i,
    input  logic             out_valid_i,
    input  logic             out_ready_i,
    output ctrl_engine_t     ctrl_o,
    output logic             load_req_o,
    output logic             store_req_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [BLK_W-1:0] blk_cnt_o
);

    localparam int unsigned WORD_W = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;
    localparam int unsigned PROC_W = (PROC_CYCLES > 1) ? $clog2(PROC_CYCLES) : 1;

    aes_ctrl_state_t  state_q, state_d;
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic [BLK_W-1:0] nb_q, nb_d;
    logic             word_en, word_tc, proc_load, proc_tc;
    logic [WORD_W-1:0] word_cnt;
    logic [PROC_W-1:0] unused_proc_cnt;

    logic load_req_q, store_req_q, busy_q, done_q, dvalid_q, clr_q;

    aes_ctrl_counter #(.N(NB_WORDS), .DOWN(1'b0)) u_word_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (clear_i),
        .load_i (1'b0),
        .en_i   (word_en),
        .cnt_o  (word_cnt),
        .tc_c_o (word_tc)
    );

    aes_ctrl_counter #(.N(PROC_CYCLES), .DOWN(1'b1)) u_proc_tmr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (clear_i),
        .load_i (proc_load),
        .en_i   (state_q == ST_PROC),
        .cnt_o  (unused_proc_cnt),
        .tc_c_o (proc_tc)
    );

    // next-state logic; clear_i overrides everything, including a same-cycle handshake
    always_comb begin
        state_d   = state_q;
        blk_cnt_d = blk_cnt_q;
        nb_d      = nb_q;
        word_en   = 1'b0;
        proc_load = 1'b0;
        if (clear_i) begin
            state_d   = ST_IDLE;
            blk_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        blk_cnt_d = '0;
                        nb_d      = nb_blocks_i;
                        state_d   = (nb_blocks_i == '0) ? ST_DONE : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    word_en = in_valid_i & in_ready_i;
                    if (word_en && word_tc) begin
                        state_d   = ST_PROC;
                        proc_load = 1'b1;
                    end
                end
                ST_PROC: begin
                    if (proc_tc) begin
                        state_d = ST_STORE;
                    end
                end
                ST_STORE: begin
                    word_en = out_valid_i & out_ready_i;
                    if (word_en && word_tc) begin
                        blk_cnt_d = (blk_cnt_q == '1) ? blk_cnt_q : blk_cnt_q + BLK_W'(1);
                        state_d   = (blk_cnt_d == nb_q) ? ST_DONE : ST_LOAD;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            blk_cnt_q <= '0;
            nb_q      <= '0;
        end else begin
            state_q   <= state_d;
            blk_cnt_q <= blk_cnt_d;
            nb_q      <= nb_d;
        end
    end

    // registered status/request outputs; done trails the DONE state by one cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            load_req_q  <= 1'b0;
            store_req_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dvalid_q    <= 1'b0;
            clr_q       <= 1'b0;
        end else begin
            load_req_q  <= (state_d == ST_LOAD) && (state_q != ST_LOAD);
            store_req_q <= (state_d == ST_STORE) && (state_q != ST_STORE);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_q == ST_DONE) && !clear_i;
            dvalid_q    <= (state_d == ST_STORE);
            clr_q       <= clear_i;
        end
    end

    assign ctrl_o.request_counter = AES_RC_W'(word_cnt);
    assign ctrl_o.data_out_valid  = dvalid_q;
    assign ctrl_o.clear           = clr_q;
    assign load_req_o             = load_req_q;
    assign store_req_o            = store_req_q;
    assign busy_o                 = busy_q;
    assign done_o                 = done_q;
    assign blk_cnt_o              = blk_cnt_q;

endmodule
